// File: rtl/id_pkg.sv
package id_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef logic signed [WIDTH_DEFAULT-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN,
    DONE
  } state_t;

  // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  localparam sample_t CORNER_ZERO = 16'sh0000;
  localparam sample_t CORNER_MAX  = 16'sh7FFF;
  localparam sample_t CORNER_MIN  = 16'sh8000;
  localparam sample_t CORNER_NEG1 = 16'shFFFF;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/id_stim_lfsr.sv
module id_stim_lfsr
  import id_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic [15:0] idx,
  output sample_t     sample
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? SEED_DEFAULT : SEED;

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= '0;
    end else if (load) begin
      r_lfsr <= SEED_EFF;
    end else if (advance) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  always_comb begin
    sample = sample_t'(r_lfsr);
    case (idx)
      16'd0:   sample = CORNER_ZERO;
      16'd1:   sample = CORNER_MAX;
      16'd2:   sample = CORNER_MIN;
      16'd3:   sample = CORNER_NEG1;
      default: sample = sample_t'(r_lfsr);
    endcase
  end

endmodule

// File: rtl/id_loopback_checker.sv
module id_loopback_checker
  import id_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned LATENCY     = 0,
  parameter int unsigned NUM_SAMPLES = 256,
  parameter logic [15:0] SEED        = SEED_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic signed [WIDTH-1:0] x_out,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_cnt,
  output logic [15:0]             first_err_idx
);

  localparam logic [15:0] IDX_LAST   = 16'(NUM_SAMPLES - 1);
  localparam logic [3:0]  DRAIN_LAST = 4'(LATENCY - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [15:0]             r_idx;
  logic signed [WIDTH-1:0] r_x;
  logic [3:0]              r_drain;
  logic [15:0]             r_err;
  logic [15:0]             r_first;
  logic                    r_pass;

  logic                    w_start_ok;
  logic                    w_last;
  logic                    w_step;
  logic                    w_take;
  logic [15:0]             w_idx_nxt;
  sample_t                 w_sample;
  logic                    w_cur_vld;
  logic                    w_exp_vld;
  logic signed [WIDTH-1:0] w_exp_val;
  logic [15:0]             w_exp_idx;
  logic                    w_mismatch;

  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last     = (r_state == DRIVE) && (r_idx == IDX_LAST);
  assign w_step     = (r_state == DRIVE) && !w_last;
  assign w_take     = w_start_ok || w_step;
  assign w_idx_nxt  = w_start_ok ? 16'd0 : r_idx + 16'd1;
  assign w_cur_vld  = (r_state == DRIVE);

  // LFSR only advances once its value has been consumed for idx >= 4
  id_stim_lfsr #(
    .SEED(SEED)
  ) u_stim (
    .clk    (clk),
    .rst    (rst),
    .load   (w_start_ok),
    .advance(w_step && (w_idx_nxt >= 16'd4)),
    .idx    (w_idx_nxt),
    .sample (w_sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = DRIVE;
      DRIVE:   if (w_last) w_state_nxt = (LATENCY == 0) ? DONE : DRAIN;
      DRAIN:   if (r_drain == DRAIN_LAST) w_state_nxt = DONE;
      DONE:    if (start) w_state_nxt = DRIVE;
      default: w_state_nxt = IDLE;
    endcase
  end

  generate
    if (LATENCY == 0) begin : g_nodly
      always_comb begin
        w_exp_vld = w_cur_vld;
        w_exp_val = r_x;
        w_exp_idx = r_idx;
      end
    end else begin : g_dly
      logic [LATENCY-1:0]      r_vld;
      logic signed [WIDTH-1:0] r_val [LATENCY];
      logic [15:0]             r_didx[LATENCY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= '0;
          for (int unsigned i = 0; i < LATENCY; i++) begin
            r_val[i]  <= '0;
            r_didx[i] <= '0;
          end
        end else begin
          r_vld[0]  <= w_cur_vld;
          r_val[0]  <= r_x;
          r_didx[0] <= r_idx;
          for (int unsigned i = 1; i < LATENCY; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_val[i]  <= r_val[i-1];
            r_didx[i] <= r_didx[i-1];
          end
        end
      end

      always_comb begin
        w_exp_vld = r_vld[LATENCY-1];
        w_exp_val = r_val[LATENCY-1];
        w_exp_idx = r_didx[LATENCY-1];
      end
    end
  endgenerate

  assign w_mismatch = w_exp_vld && (y_in != w_exp_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_x     <= '0;
      r_drain <= '0;
      r_err   <= '0;
      r_first <= '0;
      r_pass  <= 1'b0;
    end else begin
      if (w_take) begin
        r_idx <= w_idx_nxt;
        r_x   <= WIDTH'(w_sample);
      end else if (w_last) begin
        r_x <= '0;
      end

      r_drain <= (r_state == DRAIN) ? r_drain + 4'd1 : 4'd0;

      if (w_start_ok) begin
        r_err   <= '0;
        r_first <= '0;
        r_pass  <= 1'b0;
      end else begin
        if (w_mismatch) begin
          if (r_err != '1) r_err <= r_err + 16'd1;
          if (r_err == '0) r_first <= w_exp_idx;
        end
        // the final comparison lands on the same edge that enters DONE
        if ((w_state_nxt == DONE) && (r_state != DONE)) begin
          r_pass <= (r_err == '0) && !w_mismatch;
        end
      end
    end
  end

  assign x_out         = r_x;
  assign busy          = (r_state == DRIVE) || (r_state == DRAIN);
  assign done          = (r_state == DONE);
  assign pass          = r_pass;
  assign err_cnt       = r_err;
  assign first_err_idx = r_first;

endmodule

// File: tb/tb_id_loopback_checker.sv
module tb_id_loopback_checker;

  localparam int unsigned NI = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0]      st;
  logic [NI-1:0]      bz;
  logic [NI-1:0]      dn;
  logic [NI-1:0]      ps;
  logic signed [15:0] xo [NI];
  logic [15:0]        ec [NI];
  logic [15:0]        fi [NI];

  logic signed [15:0] y_a, y_b, y_c, y_d, y_e, y_f;
  logic signed [15:0] b_p1 = '0, b_p2 = '0, c_p1 = '0, c_p2 = '0;

  always @(posedge clk) begin
    b_p1 <= xo[1];
    b_p2 <= b_p1;
    c_p1 <= xo[2];
    c_p2 <= c_p1;
  end

  assign y_a = xo[0];
  assign y_b = b_p2;
  assign y_c = c_p2;
  assign y_d = {1'b0, xo[3][14:0]};
  assign y_e = xo[4];
  // 16'h59C3 is the one LFSR state just before the seed, never reached within a run
  assign y_f = 16'sh59C3;

  id_loopback_checker #(.WIDTH(16), .LATENCY(0), .NUM_SAMPLES(8), .SEED(16'hACE1)) uA (
    .clk(clk), .rst(rst), .start(st[0]), .x_out(xo[0]), .y_in(y_a), .busy(bz[0]),
    .done(dn[0]), .pass(ps[0]), .err_cnt(ec[0]), .first_err_idx(fi[0]));
  id_loopback_checker #(.WIDTH(16), .LATENCY(2), .NUM_SAMPLES(16), .SEED(16'hACE1)) uB (
    .clk(clk), .rst(rst), .start(st[1]), .x_out(xo[1]), .y_in(y_b), .busy(bz[1]),
    .done(dn[1]), .pass(ps[1]), .err_cnt(ec[1]), .first_err_idx(fi[1]));
  id_loopback_checker #(.WIDTH(16), .LATENCY(1), .NUM_SAMPLES(16), .SEED(16'hACE1)) uC (
    .clk(clk), .rst(rst), .start(st[2]), .x_out(xo[2]), .y_in(y_c), .busy(bz[2]),
    .done(dn[2]), .pass(ps[2]), .err_cnt(ec[2]), .first_err_idx(fi[2]));
  id_loopback_checker #(.WIDTH(16), .LATENCY(0), .NUM_SAMPLES(8), .SEED(16'h0000)) uD (
    .clk(clk), .rst(rst), .start(st[3]), .x_out(xo[3]), .y_in(y_d), .busy(bz[3]),
    .done(dn[3]), .pass(ps[3]), .err_cnt(ec[3]), .first_err_idx(fi[3]));
  id_loopback_checker #(.WIDTH(16), .LATENCY(0), .NUM_SAMPLES(256), .SEED(16'hACE1)) uE (
    .clk(clk), .rst(rst), .start(st[4]), .x_out(xo[4]), .y_in(y_e), .busy(bz[4]),
    .done(dn[4]), .pass(ps[4]), .err_cnt(ec[4]), .first_err_idx(fi[4]));
  id_loopback_checker #(.WIDTH(16), .LATENCY(0), .NUM_SAMPLES(65535), .SEED(16'hACE1)) uF (
    .clk(clk), .rst(rst), .start(st[5]), .x_out(xo[5]), .y_in(y_f), .busy(bz[5]),
    .done(dn[5]), .pass(ps[5]), .err_cnt(ec[5]), .first_err_idx(fi[5]));

  typedef struct {
    int unsigned inst;
    int unsigned len;
    logic        pass;
    logic [15:0] err;
    logic [15:0] first;
    logic        chk_first;
    int unsigned t0;
  } res_t;

  res_t               res_q[$];
  logic signed [15:0] smp_q[$];
  int unsigned        n_chk  = 0;
  int unsigned        n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Hand-computed x_out sequence for an 8-sample run from seed ACE1
  task automatic push_samples_a();
    logic signed [15:0] tbl [8];
    tbl = '{16'sh0000, 16'sh7FFF, 16'sh8000, 16'shFFFF,
            16'shACE1, 16'sh5670, 16'shAB38, 16'sh559C};
    for (int i = 0; i < 8; i++) smp_q.push_back(tbl[i]);
  endtask

  task automatic run(input int unsigned k, input int unsigned len, input logic p,
                     input logic [15:0] e, input logic [15:0] f, input logic cf);
    res_t r;
    r.inst = k; r.len = len; r.pass = p; r.err = e; r.first = f; r.chk_first = cf;
    r.t0 = cyc;
    res_q.push_back(r);
    st[k] = 1'b1;
    @(negedge clk);
    st[k] = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n = 0;
    while ((res_q.size() != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (res_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout: %0d runs still pending, required 0", res_q.size());
      res_q.delete();
    end
  endtask

  logic [NI-1:0] dn_q = '0;

  // Monitor: completion records on done rising, x_out samples of uA while busy
  always @(negedge clk) begin
    res_t r;
    logic signed [15:0] s;
    for (int i = 0; i < NI; i++) begin
      if (dn[i] === 1'b1 && dn_q[i] !== 1'b1) begin
        if (res_q.size() == 0) begin
          chk($sformatf("unexpected_done%0d", i), 32'd1, 32'd0);
        end else begin
          r = res_q.pop_front();
          chk($sformatf("run%0d.inst", r.inst), i, r.inst);
          chk($sformatf("run%0d.len", r.inst), cyc - r.t0, r.len);
          chk($sformatf("run%0d.pass", r.inst), 32'(ps[i]), 32'(r.pass));
          chk($sformatf("run%0d.err_cnt", r.inst), 32'(ec[i]), 32'(r.err));
          if (r.chk_first) chk($sformatf("run%0d.first_err_idx", r.inst), 32'(fi[i]), 32'(r.first));
        end
      end
    end
    dn_q = dn;
    if (bz[0] === 1'b1) begin
      if (smp_q.size() == 0) begin
        chk("A.unexpected_sample", 32'd1, 32'd0);
      end else begin
        s = smp_q.pop_front();
        chk("A.x_out", 32'(xo[0]), 32'(s));
      end
    end
  end

  initial begin
    rst = 1'b1;
    st  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset%0d.x_out", i), 32'(xo[i]), 32'd0);
      chk($sformatf("reset%0d.busy", i), 32'(bz[i]), 32'd0);
      chk($sformatf("reset%0d.done", i), 32'(dn[i]), 32'd0);
      chk($sformatf("reset%0d.pass", i), 32'(ps[i]), 32'd0);
      chk($sformatf("reset%0d.err_cnt", i), 32'(ec[i]), 32'd0);
      chk($sformatf("reset%0d.first_err_idx", i), 32'(fi[i]), 32'd0);
    end

    // A: clean loop, extra start mid-DRIVE must not change the run length
    push_samples_a();
    run(0, 9, 1'b1, 16'd0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    wait_drain(40);
    chk("A.samples_left", smp_q.size(), 32'd0);

    // A: restart from DONE, sequence starts again at idx0
    push_samples_a();
    run(0, 9, 1'b1, 16'd0, 16'd0, 1'b0);
    chk("A.restart.done", 32'(dn[0]), 32'd0);
    chk("A.restart.busy", 32'(bz[0]), 32'd1);
    wait_drain(40);
    chk("A.restart.samples_left", smp_q.size(), 32'd0);

    // B: checker latency matches a 2-register chain
    run(1, 19, 1'b1, 16'd0, 16'd0, 1'b0);
    wait_drain(40);

    // C: chain one cycle longer than LATENCY; idx0 meets the zero from before the run
    run(2, 18, 1'b0, 16'd15, 16'd1, 1'b1);
    wait_drain(40);

    // D: bit15 stuck low, seed 0 falls back to ACE1
    run(3, 9, 1'b0, 16'd4, 16'd2, 1'b1);
    wait_drain(40);
    run(3, 9, 1'b0, 16'd4, 16'd2, 1'b1);
    chk("D.restart.err_cnt", 32'(ec[3]), 32'd0);
    chk("D.restart.first_err_idx", 32'(fi[3]), 32'd0);
    chk("D.restart.done", 32'(dn[3]), 32'd0);
    chk("D.restart.pass", 32'(ps[3]), 32'd0);
    wait_drain(40);

    // E: reset at idx5 of a long run, then a clean full run
    st[4] = 1'b1;
    @(negedge clk);
    st[4] = 1'b0;
    repeat (5) @(negedge clk);
    chk("E.idx5", 32'(xo[4]), 32'(16'sh5670));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("E.rst.x_out", 32'(xo[4]), 32'd0);
    chk("E.rst.busy", 32'(bz[4]), 32'd0);
    chk("E.rst.done", 32'(dn[4]), 32'd0);
    chk("E.rst.pass", 32'(ps[4]), 32'd0);
    chk("E.rst.err_cnt", 32'(ec[4]), 32'd0);
    chk("E.rst.first_err_idx", 32'(fi[4]), 32'd0);
    @(negedge clk);
    run(4, 257, 1'b1, 16'd0, 16'd0, 1'b0);
    wait_drain(400);

    // F: every sample mismatches, count tops out at FFFF
    run(5, 65536, 1'b0, 16'hFFFF, 16'd0, 1'b1);
    wait_drain(70000);
    repeat (2) @(negedge clk);
    chk("F.err_hold", 32'(ec[5]), 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
